// File: rtl/processor_input_pio.sv
// Avalon-MM parallel input port: synchronized, debounced inputs with sticky
// write-1-to-clear edge capture and a masked level interrupt.
module processor_input_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;

  logic             wr_en;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // An accepted bit takes the sync2 level, so that level is the new stable value.
  assign rise = accept & sync2;
  assign fall = accept & ~sync2;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set = rise;
      1:       edge_set = fall;
      default: edge_set = rise | fall;
    endcase
  end

  assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Input synchronizer and per-bit debouncer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register file: set beats clear on the capture bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask     <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && address == 2'd1) mask <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(stable);
      2'd1:    readdata = 32'(mask);
      2'd3:    readdata = 32'(edge_cap);
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & mask);

endmodule

// File: tb/tb_processor_input_pio.sv
// Randomized bench for processor_input_pio: three instances (rising, falling,
// any-edge capture) share one bus and input stream, compared against a model.
module tb_processor_input_pio;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd [3];
  logic        irq_o [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  processor_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_o[0]));

  processor_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_o[1]));

  processor_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_o[2]));

  // Reference model: input history, run length of each delayed level, registers
  logic [3:0] samp_q [$];
  logic [3:0] m_stable;
  logic [3:0] m_mask;
  logic [3:0] m_last;
  logic [3:0] m_edge [3];
  int         m_run [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    m_stable = '0;
    m_mask   = '0;
    m_last   = '0;
    for (int m = 0; m < 3; m++) m_edge[m] = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] lvl, rise, fall, clr;
    rise = '0;
    fall = '0;
    clr  = '0;
    samp_q.push_back(in_port);
    if (samp_q.size() > 3) void'(samp_q.pop_front());
    // Level seen by the debouncer is the input sampled two edges earlier.
    lvl = (samp_q.size() == 3) ? samp_q[0] : 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = (lvl[i] == m_last[i]) ? m_run[i] + 1 : 1;
      if (lvl[i] != m_stable[i] && m_run[i] >= D) begin
        m_stable[i] = lvl[i];
        if (lvl[i]) rise[i] = 1'b1;
        else        fall[i] = 1'b1;
      end
    end
    m_last = lvl;
    if (chipselect && !write_n) begin
      if (address == 2'd1) m_mask = writedata[3:0];
      if (address == 2'd3) clr = writedata[3:0];
    end
    m_edge[0] = (m_edge[0] & ~clr) | rise;
    m_edge[1] = (m_edge[1] & ~clr) | fall;
    m_edge[2] = (m_edge[2] & ~clr) | rise | fall;
  endtask

  function automatic logic [31:0] exp_rd(input int m, input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_stable};
      2'd1:    return {28'h0, m_mask};
      2'd3:    return {28'h0, m_edge[m]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rd%0d_a%0d", m, address), rd[m], exp_rd(m, address));
      chk($sformatf("irq%0d", m), {31'h0, irq_o[m]}, {31'h0, |(m_edge[m] & m_mask)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
    address    = 2'($urandom_range(0, 3));
    #1;
    check_all();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    step();
  endtask

  task automatic peek(input logic [1:0] a, input int m, output logic [31:0] v);
    address = a;
    #1;
    v = rd[m];
  endtask

  task automatic do_reset();
    logic [31:0] v;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int a = 0; a < 4; a++) begin
      for (int m = 0; m < 3; m++) begin
        peek(2'(a), m, v);
        chk($sformatf("reset_rd%0d_a%0d", m, a), v, 32'h0);
      end
    end
    chk("reset_irq", {29'h0, irq_o[0], irq_o[1], irq_o[2]}, 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int hold;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Rising edge latency with mask on bit 0
    bus_write(2'd1, 32'h1);
    in_port = 4'h1;
    for (int s = 1; s <= 18; s++) begin
      step();
      peek(2'd0, 0, v);
      chk($sformatf("rise_data_s%0d", s), v, (s <= 17) ? 32'h0 : 32'h1);
      peek(2'd3, 0, v);
      chk($sformatf("rise_edge_s%0d", s), v, (s <= 17) ? 32'h0 : 32'h1);
      chk($sformatf("rise_irq_s%0d", s), {31'h0, irq_o[0]}, (s <= 17) ? 32'h0 : 32'h1);
    end
    in_port = 4'h0;
    repeat (20) step();
    bus_write(2'd3, 32'hF);

    // Glitch rejection on bit 2, then a pulse just long enough
    in_port = 4'h4;
    repeat (15) step();
    in_port = 4'h0;
    repeat (30) step();
    peek(2'd0, 0, v);
    chk("glitch_data", v, 32'h0);
    peek(2'd3, 0, v);
    chk("glitch_edge", v, 32'h0);
    chk("glitch_irq", {31'h0, irq_o[0]}, 32'h0);
    in_port = 4'h4;
    repeat (16) step();
    in_port = 4'h0;
    repeat (30) step();
    peek(2'd3, 0, v);
    chk("pulse16_edge", v, 32'h4);

    // Write-1-to-clear and masking
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    repeat (20) step();
    peek(2'd3, 0, v);
    chk("w1c_all", v, 32'hF);
    bus_write(2'd3, 32'h5);
    peek(2'd3, 0, v);
    chk("w1c_partial", v, 32'hA);
    bus_write(2'd1, 32'h5);
    chk("mask5_irq", {31'h0, irq_o[0]}, 32'h0);
    bus_write(2'd1, 32'h2);
    chk("mask2_irq", {31'h0, irq_o[0]}, 32'h1);

    // Detect and clear on the same edge: set wins
    in_port = 4'h0;
    repeat (20) step();
    bus_write(2'd3, 32'hF);
    in_port = 4'h1;
    repeat (17) step();
    bus_write(2'd3, 32'h1);
    peek(2'd3, 0, v);
    chk("set_wins", v & 32'h1, 32'h1);

    // Falling and any-edge modes on bit 3
    in_port = 4'h0;
    repeat (20) step();
    bus_write(2'd3, 32'hF);
    in_port = 4'h8;
    repeat (20) step();
    peek(2'd3, 1, v);
    chk("fall_after_rise", v, 32'h0);
    peek(2'd3, 2, v);
    chk("any_after_rise", v, 32'h8);
    bus_write(2'd3, 32'h8);
    peek(2'd3, 2, v);
    chk("any_cleared", v, 32'h0);
    in_port = 4'h0;
    repeat (20) step();
    peek(2'd3, 1, v);
    chk("fall_after_fall", v, 32'h8);
    peek(2'd3, 2, v);
    chk("any_after_fall", v, 32'h8);

    // Reset mid-debounce with inputs held high through reset
    in_port = 4'hF;
    repeat (8) step();
    do_reset();
    repeat (20) step();
    peek(2'd3, 0, v);
    chk("held_high_rise", v, 32'hF);

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        in_port = 4'($urandom);
        hold = $urandom_range(1, 24);
      end
      hold--;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 9) == 0) begin
        bus_write(2'($urandom_range(0, 3)), $urandom);
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
